fixed_pri_grant_lock: RTL

- Sequential stage directly downstream of the combinational fixed-priority arbiter (LSB highest priority).
- Samples the arbiter's one-hot grant, registers it, and holds it stable for a multi-beat transaction until the owner signals its last beat, drops its request, or hits the optional beat limit.
- Presents a registered one-hot grant, a binary owner index and a beat counter to the shared-resource mux.

---
 rtl/fixed_pri_pkg.sv | 16 +
 rtl/onehot_to_bin.sv | 21 ++
 rtl/fixed_pri_grant_lock.sv | 118 +++++++++++
 3 files changed

// File: rtl/fixed_pri_pkg.sv
// Shared types and helpers for the fixed-priority grant-lock stage.
package fixed_pri_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int unsigned DEFAULT_N = 8;

  // Width of a binary index for n items, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder; multi-hot input yields the lowest set index
// and raises multihot_o.
module onehot_to_bin #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     oh_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             multihot_o
);

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (oh_i[i-1]) idx_o = IDX_W'(i - 1);
    end
    multihot_o = |(oh_i & (oh_i - N'(1)));
  end

endmodule

// File: rtl/fixed_pri_grant_lock.sv
// Holds the fixed-priority arbiter's grant for a multi-beat transaction.
// Optional beat-limit release: define GRANT_LOCK_MAXBEAT_EN.
module fixed_pri_grant_lock
  import fixed_pri_pkg::*;
#(
  parameter int unsigned N         = DEFAULT_N,
  parameter int unsigned IDX_W     = clog2_min1(N),
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     arb_gnt,
  input  logic [N-1:0]     req_last,
  input  logic             out_ready,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             beat_fire,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             onehot_err
);

  lock_state_e      state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_multihot;
  logic             owner_req;
  logic             owner_last;
  logic             release_lock;

  onehot_to_bin #(
    .N    (N),
    .IDX_W(IDX_W)
  ) u_enc (
    .oh_i      (arb_gnt),
    .idx_o     (enc_idx),
    .multihot_o(enc_multihot)
  );

  assign owner_req  = req[idx_q];
  assign owner_last = req_last[idx_q];
  assign gnt_valid  = (state_q == LOCKED);
  assign beat_fire  = gnt_valid & owner_req & out_ready;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    release_lock = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          state_d = LOCKED;
          // Rebuild the grant from the encoded index so a multi-hot
          // arbiter output still locks exactly one requester.
          gnt_d   = N'(1) << enc_idx;
          idx_d   = enc_idx;
          cnt_d   = '0;
          if (enc_multihot) err_d = 1'b1;
        end
      end
      LOCKED: begin
        if (!owner_req) begin
          release_lock = 1'b1;
        end else if (beat_fire) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (owner_last) begin
            release_lock = 1'b1;
          end
`ifdef GRANT_LOCK_MAXBEAT_EN
          else if (cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            release_lock = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (release_lock) begin
      state_d = IDLE;
      gnt_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_idx    = idx_q;
  assign beat_cnt   = cnt_q;
  assign onehot_err = err_q;

endmodule
